// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer: entry layout, the opcodes
// that never write the register file, and the regwrite decode.
package rob_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef struct packed {
      logic        valid;
      logic        ready;
      logic        regwrite;
      logic [4:0]  rd;
      logic [31:0] value;
   } rob_entry_t;

   // Branches and stores produce no register result; writes to x0 are dropped.
   function automatic logic needs_regwrite(input logic [6:0] opcode, input logic [4:0] rd);
      return !(opcode == OPC_BRANCH || opcode == OPC_STORE) && (rd != 5'd0);
   endfunction

endpackage

// File: rtl/rob_if.sv
// Issue / CDB / operand-lookup / commit bundle of the reorder buffer.
// The master side drives requests, the slave side (the ROB) answers.
interface rob_if #(
   parameter int ROB_DEPTH = 3
);
   logic                 flush;
   logic                 issue;
   logic [6:0]           issue_opcode;
   logic [4:0]           issue_rd_s;
   logic [ROB_DEPTH-1:0] issue_rob;
   logic                 rob_full;
   logic                 rob_empty;
   logic                 cdb_valid;
   logic [ROB_DEPTH-1:0] cdb_rob;
   logic [31:0]          cdb_rd_v;
   logic [ROB_DEPTH-1:0] rs1_rob;
   logic [ROB_DEPTH-1:0] rs2_rob;
   logic                 rs1_rob_ready;
   logic                 rs2_rob_ready;
   logic [31:0]          rs1_rob_v;
   logic [31:0]          rs2_rob_v;
   logic                 commit_reg_write;
   logic [4:0]           commit_rd_s;
   logic [31:0]          commit_rd_v;
   logic [ROB_DEPTH-1:0] commit_rob;

   modport master (
      output flush, issue, issue_opcode, issue_rd_s,
      output cdb_valid, cdb_rob, cdb_rd_v, rs1_rob, rs2_rob,
      input  issue_rob, rob_full, rob_empty,
      input  rs1_rob_ready, rs2_rob_ready, rs1_rob_v, rs2_rob_v,
      input  commit_reg_write, commit_rd_s, commit_rd_v, commit_rob
   );

   modport slave (
      input  flush, issue, issue_opcode, issue_rd_s,
      input  cdb_valid, cdb_rob, cdb_rd_v, rs1_rob, rs2_rob,
      output issue_rob, rob_full, rob_empty,
      output rs1_rob_ready, rs2_rob_ready, rs1_rob_v, rs2_rob_v,
      output commit_reg_write, commit_rd_s, commit_rd_v, commit_rob
   );
endinterface

// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, captures CDB results,
// answers operand-tag lookups (with same-cycle CDB bypass) and commits in order.
module rob
   import rob_pkg::*;
#(
   parameter int ROB_DEPTH = 3
) (
   input logic   clk,
   input logic   rst,
   rob_if.slave  bus
);
   localparam int ENTRIES = 1 << ROB_DEPTH;

   logic [ROB_DEPTH:0]   head_reg, head_next;
   logic [ROB_DEPTH:0]   tail_reg, tail_next;
   logic [ROB_DEPTH-1:0] head_idx, tail_idx;
   logic                 full, empty, alloc, commit;
   rob_entry_t           entries [ENTRIES];
   rob_entry_t           head_entry;
   logic [32:0]          rs1_look, rs2_look;

   assign head_idx   = head_reg[ROB_DEPTH-1:0];
   assign tail_idx   = tail_reg[ROB_DEPTH-1:0];
   assign empty      = (head_reg == tail_reg);
   assign full       = (head_idx == tail_idx) && (head_reg[ROB_DEPTH] != tail_reg[ROB_DEPTH]);
   assign alloc      = bus.issue && !full && !bus.flush;
   assign head_entry = entries[head_idx];
   // Uses the registered ready bit only, so a CDB write to the head commits a cycle later.
   assign commit     = head_entry.valid && head_entry.ready && !bus.flush;

   always_comb begin
      head_next = head_reg;
      tail_next = tail_reg;
      if (bus.flush) begin
         head_next = '0;
         tail_next = '0;
      end else begin
         if (alloc)  tail_next = tail_reg + 1'b1;
         if (commit) head_next = head_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg <= '0;
         tail_reg <= '0;
      end else begin
         head_reg <= head_next;
         tail_reg <= tail_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         localparam logic [ROB_DEPTH-1:0] IDX = ROB_DEPTH'(gi);
         rob_entry_t e_reg;

         // Allocation only targets a free tail slot and commit only the head,
         // so the branches below never compete for a live entry.
         always_ff @(posedge clk) begin
            if (rst || bus.flush) begin
               e_reg <= '0;
            end else if (alloc && tail_idx == IDX) begin
               e_reg.valid    <= 1'b1;
               e_reg.ready    <= 1'b0;
               e_reg.regwrite <= needs_regwrite(bus.issue_opcode, bus.issue_rd_s);
               e_reg.rd       <= bus.issue_rd_s;
               e_reg.value    <= '0;
            end else if (commit && head_idx == IDX) begin
               e_reg <= '0;
            end else if (bus.cdb_valid && bus.cdb_rob == IDX && e_reg.valid) begin
               e_reg.ready <= 1'b1;
               e_reg.value <= bus.cdb_rd_v;
            end
         end

         assign entries[gi] = e_reg;
      end
   endgenerate

   function automatic logic [32:0] lookup(
      input logic [ROB_DEPTH-1:0] tag,
      input rob_entry_t           e,
      input logic                 cdb_v,
      input logic [ROB_DEPTH-1:0] cdb_tag,
      input logic [31:0]          cdb_val
   );
      if (cdb_v && cdb_tag == tag) return {1'b1, cdb_val};
      if (e.ready)                 return {1'b1, e.value};
      return 33'd0;
   endfunction

   assign rs1_look = lookup(bus.rs1_rob, entries[bus.rs1_rob], bus.cdb_valid, bus.cdb_rob, bus.cdb_rd_v);
   assign rs2_look = lookup(bus.rs2_rob, entries[bus.rs2_rob], bus.cdb_valid, bus.cdb_rob, bus.cdb_rd_v);

   assign bus.issue_rob        = tail_idx;
   assign bus.rob_full         = full;
   assign bus.rob_empty        = empty;
   assign bus.rs1_rob_ready    = rs1_look[32];
   assign bus.rs1_rob_v        = rs1_look[31:0];
   assign bus.rs2_rob_ready    = rs2_look[32];
   assign bus.rs2_rob_v        = rs2_look[31:0];
   assign bus.commit_reg_write = commit && head_entry.regwrite && !rst;
   assign bus.commit_rd_s      = head_entry.rd;
   assign bus.commit_rd_v      = head_entry.value;
   assign bus.commit_rob       = head_idx;

endmodule
